// File: rtl/d_memory_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store,
// served from a word array after LATENCY cycles with a one-cycle ack.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

package d_memory_pkg;
    typedef enum logic [1:0] {
        mem_read  = 2'd0,
        mem_write = 2'd1,
        mem_nop   = 2'd2,
        mem_rsvd  = 2'd3
    } memory_op_t;
endpackage

module d_memory_responder
    import d_memory_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            memory_req_valid,
    input  memory_op_t                      memory_req_op,
    input  logic [`D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
    input  logic [`REG_VAL_WIDTH-1:0]       memory_req_data,
    output logic                            memory_ready,
    output logic                            memory_ack,
    output logic [`REG_VAL_WIDTH-1:0]       memory_data_return,
    output logic                            memory_err
);

    localparam int DW = `REG_VAL_WIDTH;
    localparam int AW = `D_MEMORY_ADDR_WIDTH;
    localparam int BS = $clog2(DW / 8);
    localparam int IW = AW - BS;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    memory_op_t      op_q, op_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            mem_we;
    logic            in_range;
    logic            unused_addr_bits;

    // Byte offset inside a word plays no role in addressing.
    assign unused_addr_bits = ^memory_req_address[BS-1:0];
    assign in_range = 32'(idx_q) < 32'(DEPTH);

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        op_d               = op_q;
        idx_d              = idx_q;
        data_d             = data_q;
        mem_we             = 1'b0;
        memory_ready       = 1'b0;
        memory_ack         = 1'b0;
        memory_data_return = '0;
        memory_err         = 1'b0;
        unique case (state_q)
            IDLE: begin
                memory_ready = 1'b1;
                if (memory_req_valid) begin
                    op_d    = memory_req_op;
                    idx_d   = memory_req_address[AW-1:BS];
                    data_d  = memory_req_data;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACK: begin
                memory_ack = 1'b1;
                state_d    = IDLE;
                if (op_q == mem_read || op_q == mem_write) begin
                    if (!in_range) begin
                        memory_err = 1'b1;
                    end else if (op_q == mem_read) begin
                        memory_data_return = mem_q[idx_q[MW-1:0]];
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over everything, including a store landing this edge.
        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= mem_nop;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q[MW-1:0]] <= data_q;
        end
    end

endmodule

// File: tb/tb_d_memory_responder.sv
// Directed vector bench for d_memory_responder: table of single
// transactions plus hand-built busy-hold and reset-abort sequences.
module tb_d_memory_responder;
    import d_memory_pkg::*;

    localparam int LAT = 8;
    localparam int DEP = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    memory_op_t  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        ready;
    logic        ack;
    logic [31:0] data_ret;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;
    int mon_bad = 0;
    bit pending = 0;
    bit prev_ack = 0;

    d_memory_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk                (clk),
        .reset              (reset),
        .memory_req_valid   (req_valid),
        .memory_req_op      (req_op),
        .memory_req_address (req_addr),
        .memory_req_data    (req_data),
        .memory_ready       (ready),
        .memory_ack         (ack),
        .memory_data_return (data_ret),
        .memory_err         (err)
    );

    always #5 clk = ~clk;

    // Every ack must follow exactly one acceptance and last one cycle.
    always @(posedge clk) begin
        if (ack && (!pending || prev_ack)) begin
            mon_bad++;
            $display("FAIL ack_protocol: ack=1 pending=%0d prev_ack=%0d",
                     pending, prev_ack);
        end
        prev_ack = ack;
        if (ack) pending = 0;
        if (reset) pending = 0;
        else if (ready && req_valid) pending = 1;
    end

    typedef struct {
        memory_op_t  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for the ack; returns cycles since acceptance (cycle 1 first).
    task automatic wait_ack(output int n, output bit noisy);
        n = 1;
        noisy = 0;
        while (!ack && n < 40) begin
            if (data_ret != 0 || err) noisy = 1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic txn(input string name, input memory_op_t op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        int n;
        bit noisy;
        @(negedge clk);
        check({name, "_ready_idle"}, 32'(ready), 32'd1);
        req_valid = 1;
        req_op = op;
        req_addr = addr;
        req_data = wd;
        @(negedge clk);
        req_valid = 0;
        req_addr = 32'hFFFF_FFF0;
        check({name, "_ready_busy"}, 32'(ready), 32'd0);
        wait_ack(n, noisy);
        check({name, "_latency"}, 32'(n), 32'(LAT));
        check({name, "_data"}, data_ret, exp_d);
        check({name, "_err"}, 32'(err), 32'(exp_e));
        check({name, "_quiet"}, 32'(noisy), 32'd0);
        @(negedge clk);
        check({name, "_ack_drop"}, 32'(ack), 32'd0);
        check({name, "_ready_back"}, 32'(ready), 32'd1);
        check({name, "_zero_out"}, data_ret | 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        bit noisy;
        vecs[0]  = '{mem_write, 32'h0000_2000, 32'h1111_2222, 32'h0, 1'b0};
        vecs[1]  = '{mem_read,  32'h0000_2000, 32'h0, 32'h1111_2222, 1'b0};
        vecs[2]  = '{mem_write, 32'h0000_0000, 32'hA5A5_0000, 32'h0, 1'b0};
        vecs[3]  = '{mem_read,  32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0};
        vecs[4]  = '{mem_write, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 1'b1};
        vecs[5]  = '{mem_read,  32'h0000_4000, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{mem_read,  32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0};
        vecs[7]  = '{mem_write, 32'h0000_3FFC, 32'h1234_5678, 32'h0, 1'b0};
        vecs[8]  = '{mem_read,  32'h0000_3FFF, 32'h0, 32'h1234_5678, 1'b0};
        vecs[9]  = '{mem_nop,   32'h0000_3FFC, 32'h0000_0055, 32'h0, 1'b0};
        vecs[10] = '{mem_read,  32'h0000_3FFC, 32'h0, 32'h1234_5678, 1'b0};
        vecs[11] = '{mem_write, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[12] = '{mem_read,  32'h0000_1000, 32'h0, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{mem_read,  32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1};
        vecs[14] = '{mem_rsvd,  32'h0000_4000, 32'h0, 32'h0, 1'b0};
        vecs[15] = '{mem_write, 32'h0000_0100, 32'h0000_0100, 32'h0, 1'b0};
        vecs[16] = '{mem_write, 32'h0000_0200, 32'h0000_0200, 32'h0, 1'b0};

        reset = 1;
        req_valid = 1;
        req_op = mem_write;
        req_addr = 32'h0;
        req_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        req_valid = 0;
        reset = 0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", data_ret, 32'd0);
        check("rst_err", 32'(err), 32'd0);

        for (int i = 0; i < 17; i++) begin
            txn($sformatf("v%0d", i), vecs[i].op, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Valid held through BUSY with a different address each cycle.
        @(negedge clk);
        req_valid = 1;
        req_op = mem_read;
        req_addr = 32'h0000_0100;
        @(negedge clk);
        req_addr = 32'h0000_0200;
        wait_ack(n, noisy);
        check("hold_lat1", 32'(n), 32'(LAT));
        check("hold_data1", data_ret, 32'h0000_0100);
        @(negedge clk);
        check("hold_ready_back", 32'(ready), 32'd1);
        @(negedge clk);
        req_valid = 0;
        check("hold_second_acc", 32'(ready), 32'd0);
        wait_ack(n, noisy);
        check("hold_lat2", 32'(n), 32'(LAT));
        check("hold_data2", data_ret, 32'h0000_0200);

        // Reset three cycles into a store aborts it; request during reset dropped.
        @(negedge clk);
        @(negedge clk);
        req_valid = 1;
        req_op = mem_write;
        req_addr = 32'h0000_1000;
        req_data = 32'h0000_0BAD;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        req_valid = 1;
        @(negedge clk);
        reset = 0;
        req_valid = 0;
        check("abort_ready", 32'(ready), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack || !ready) n++;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(n), 32'd0);
        txn("abort_load", mem_read, 32'h0000_1000, 32'h0,
            32'hCAFE_F00D, 1'b0);

        // Reset landing on the ack cycle must suppress the array write.
        @(negedge clk);
        req_valid = 1;
        req_op = mem_write;
        req_addr = 32'h0000_1000;
        req_data = 32'h0000_0077;
        @(negedge clk);
        req_valid = 0;
        wait_ack(n, noisy);
        check("ackrst_lat", 32'(n), 32'(LAT));
        reset = 1;
        @(negedge clk);
        reset = 0;
        txn("ackrst_load", mem_read, 32'h0000_1000, 32'h0,
            32'hCAFE_F00D, 1'b0);

        // Tight store/load/store run, each issued as ready returns.
        txn("b2b_st1", mem_write, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0, 1'b0);
        txn("b2b_ld", mem_read, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 1'b0);
        txn("b2b_st2", mem_write, 32'h0000_0044, 32'h600D_F00D, 32'h0, 1'b0);
        txn("b2b_ld2", mem_read, 32'h0000_0044, 32'h0, 32'h600D_F00D, 1'b0);

        repeat (3) @(negedge clk);
        check("ack_protocol_errs", 32'(mon_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
